// File: rtl/npc_pkg.sv
// Shared core definitions: reset PC, fetch FSM states and the EBREAK word.
package npc_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        VALID
    } ifu_state_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction memory channel: one request, one response, valid/ready.
interface ifu_fetch_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err
    );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction
// and holds it for the core until commit.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] P_RESET_PC = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master mem,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err,
    input  logic        inst_ready,
    input  logic [31:0] next_pc,
    output logic [63:0] fetch_cnt
);

    ifu_state_t  r_state;
    ifu_state_t  w_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_err;
    logic [63:0] r_cnt;
    logic        w_commit;
    logic        w_misal;
    logic        w_resp;

    assign w_commit = (r_state == VALID) && inst_ready;
    assign w_misal  = next_pc[1:0] != 2'b00;
    assign w_resp   = (r_state == WAIT) && mem.resp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  w_next = REQ;
            REQ:   if (mem.req_ready) w_next = WAIT;
            WAIT:  if (mem.resp_valid) w_next = VALID;
            VALID: if (inst_ready) w_next = w_misal ? VALID : REQ;
        endcase
    end

    always_comb begin
        mem.req_valid = r_state == REQ;
        mem.req_addr  = {r_pc[31:2], 2'b00};
        inst_valid    = r_state == VALID;
        inst          = r_inst;
        inst_pc       = r_pc;
        fetch_err     = r_err;
        fetch_cnt     = r_cnt;
    end

    // A misaligned target becomes a synthetic faulting instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= P_RESET_PC;
            r_inst <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_resp) begin
                r_inst <= mem.resp_err ? 32'h0 : mem.resp_data;
                r_err  <= mem.resp_err;
            end
            if (w_commit) begin
                r_pc  <= next_pc;
                r_cnt <= r_cnt + 64'd1;
                if (w_misal) begin
                    r_inst <= '0;
                    r_err  <= 1'b1;
                end
            end
        end
    end

    a_resp_in_wait: assert property (
        @(posedge clk) disable iff (rst)
        mem.resp_valid |-> r_state == WAIT
    );

endmodule
